// File: rtl/pixel_array_readout_if.sv
// Stream and array-side signal bundle for the row-scanning pixel readout sequencer.
// The master modport is the sequencer; the slave modport is the array/downstream side.
interface pixel_array_readout_if #(
   parameter int PIXEL_ARRAY_HEIGHT = 2,
   parameter int PIXEL_ARRAY_WIDTH  = 2,
   parameter int PIXEL_BITS         = 8
);
   localparam int RW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
   localparam int CW = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;

   logic                                      START;
   logic                                      MIRROR;
   logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   DATA_IN;
   logic [PIXEL_ARRAY_HEIGHT-1:0]             READ;
   logic [PIXEL_BITS-1:0]                     PIXEL_OUT;
   logic                                      PIXEL_VALID;
   logic                                      PIXEL_READY;
   logic [RW-1:0]                             PIXEL_ROW;
   logic [CW-1:0]                             PIXEL_COL;
   logic                                      LAST_PIXEL;
   logic                                      BUSY;
   logic                                      FRAME_DONE;

   modport master (
      input  START, MIRROR, DATA_IN, PIXEL_READY,
      output READ, PIXEL_OUT, PIXEL_VALID, PIXEL_ROW, PIXEL_COL,
             LAST_PIXEL, BUSY, FRAME_DONE
   );

   modport slave (
      output START, MIRROR, DATA_IN, PIXEL_READY,
      input  READ, PIXEL_OUT, PIXEL_VALID, PIXEL_ROW, PIXEL_COL,
             LAST_PIXEL, BUSY, FRAME_DONE
   );
endinterface

// File: rtl/pixel_array_readout.sv
// Row-scanning readout sequencer: selects each row, waits a settle time, captures the
// shared row bus and streams that row's pixels out on a valid/ready handshake.
module pixel_array_readout #(
   parameter int PIXEL_ARRAY_HEIGHT = 2,
   parameter int PIXEL_ARRAY_WIDTH  = 2,
   parameter int PIXEL_BITS         = 8,
   parameter int SETTLE_CYCLES      = 1
) (
   input  logic                          CLK,
   input  logic                          RESET,
   pixel_array_readout_if.master         bus
);
   localparam int RW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
   localparam int CW = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int DW = PIXEL_ARRAY_WIDTH * PIXEL_BITS;

   localparam logic [RW-1:0] LAST_ROW    = RW'(PIXEL_ARRAY_HEIGHT - 1);
   localparam logic [CW-1:0] LAST_COL    = CW'(PIXEL_ARRAY_WIDTH - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SELECT  = 2'd1,
      CAPTURE = 2'd2,
      SHIFT   = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [RW-1:0]   row_reg, row_next;
   logic [CW-1:0]   col_reg, col_next;
   logic [SW-1:0]   settle_reg, settle_next;
   logic            mirror_reg, mirror_next;
   logic [DW-1:0]   row_data_reg, row_data_next;
   logic            frame_done_reg, frame_done_next;

   logic                     row_active;
   logic                     in_shift;
   logic [CW-1:0]            final_col;
   logic                     at_final_col;
   logic                     at_last_row;
   logic [PIXEL_BITS-1:0]    pixels [PIXEL_ARRAY_WIDTH];
   logic [PIXEL_BITS-1:0]    pixel_sel;
   logic [PIXEL_ARRAY_HEIGHT-1:0] read_bits;

   assign row_active   = (state_reg == SELECT) || (state_reg == CAPTURE);
   assign in_shift     = (state_reg == SHIFT);
   // Mirrored frames walk from the top column down, so the row ends at column 0.
   assign final_col    = mirror_reg ? '0 : LAST_COL;
   assign at_final_col = (col_reg == final_col);
   assign at_last_row  = (row_reg == LAST_ROW);

   generate
      for (genvar gi = 0; gi < PIXEL_ARRAY_WIDTH; gi++) begin : g_pix
         assign pixels[gi] = row_data_reg[gi*PIXEL_BITS +: PIXEL_BITS];
      end
      for (genvar gi = 0; gi < PIXEL_ARRAY_HEIGHT; gi++) begin : g_read
         assign read_bits[gi] = row_active && (row_reg == RW'(gi));
      end
   endgenerate

   always_comb begin
      pixel_sel = '0;
      for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin
         if (col_reg == CW'(c)) begin
            pixel_sel = pixels[c];
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg      <= IDLE;
         row_reg        <= '0;
         col_reg        <= '0;
         settle_reg     <= '0;
         mirror_reg     <= 1'b0;
         row_data_reg   <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         row_reg        <= row_next;
         col_reg        <= col_next;
         settle_reg     <= settle_next;
         mirror_reg     <= mirror_next;
         row_data_reg   <= row_data_next;
         frame_done_reg <= frame_done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      row_next        = row_reg;
      col_next        = col_reg;
      settle_next     = settle_reg;
      mirror_next     = mirror_reg;
      row_data_next   = row_data_reg;
      frame_done_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.START) begin
               state_next  = SELECT;
               row_next    = '0;
               col_next    = '0;
               settle_next = '0;
               mirror_next = bus.MIRROR;
            end
         end

         SELECT: begin
            if (settle_reg == SETTLE_LAST) begin
               state_next = CAPTURE;
            end else begin
               settle_next = settle_reg + SW'(1);
            end
         end

         CAPTURE: begin
            state_next    = SHIFT;
            row_data_next = bus.DATA_IN;
            col_next      = mirror_reg ? LAST_COL : '0;
         end

         SHIFT: begin
            if (bus.PIXEL_READY) begin
               if (at_final_col) begin
                  if (at_last_row) begin
                     state_next      = IDLE;
                     frame_done_next = 1'b1;
                     row_next        = '0;
                     col_next        = '0;
                  end else begin
                     state_next  = SELECT;
                     row_next    = row_reg + RW'(1);
                     settle_next = '0;
                  end
               end else begin
                  col_next = mirror_reg ? (col_reg - CW'(1)) : (col_reg + CW'(1));
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Every output is decoded from registered state only; back-pressure simply freezes it.
   assign bus.READ        = read_bits;
   assign bus.PIXEL_VALID = in_shift;
   assign bus.PIXEL_OUT   = in_shift ? pixel_sel : '0;
   assign bus.PIXEL_ROW   = row_reg;
   assign bus.PIXEL_COL   = col_reg;
   assign bus.LAST_PIXEL  = in_shift && at_last_row && at_final_col;
   assign bus.BUSY        = (state_reg != IDLE);
   assign bus.FRAME_DONE  = frame_done_reg;
endmodule
